// File: rtl/vx_batch_pkg.sv
// Packet types and sizing helpers shared by the dispatch batcher and its users.
// The DEF_* types describe the default 8-thread / 4-lane / 32-bit build.
package vx_batch_pkg;

    localparam int UUID_W    = 16;
    localparam int WIS_W     = 2;
    localparam int OP_TYPE_W = 4;
    localparam int OP_MOD_W  = 3;
    localparam int REG_W     = 5;

    localparam int DEF_NUM_THREADS = 8;
    localparam int DEF_LANES       = 4;
    localparam int DEF_XLEN        = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int batches_of(input int nt, input int lanes);
        return nt / lanes;
    endfunction

    function automatic int disp_w(input int nt, input int xlen);
        return UUID_W + WIS_W + nt + OP_TYPE_W + OP_MOD_W + 3 + 2 * xlen + REG_W
             + clog2_min1(nt) + 3 * nt * xlen + 1;
    endfunction

    function automatic int batch_w(input int nt, input int lanes, input int xlen);
        return UUID_W + WIS_W + lanes + OP_TYPE_W + OP_MOD_W + 3 + 2 * xlen + REG_W
             + clog2_min1(nt) + 3 * lanes * xlen + 1
             + clog2_min1(batches_of(nt, lanes)) + 2;
    endfunction

    localparam int DEF_BATCHES = batches_of(DEF_NUM_THREADS, DEF_LANES);
    localparam int DEF_PID_W   = clog2_min1(DEF_BATCHES);
    localparam int DEF_TID_W   = clog2_min1(DEF_NUM_THREADS);

    typedef struct packed {
        logic [UUID_W-1:0]                            uuid;
        logic [WIS_W-1:0]                             wis;
        logic [DEF_NUM_THREADS-1:0]                   tmask;
        logic [OP_TYPE_W-1:0]                         op_type;
        logic [OP_MOD_W-1:0]                          op_mod;
        logic                                         wb;
        logic                                         use_PC;
        logic                                         use_imm;
        logic [DEF_XLEN-1:0]                          PC;
        logic [DEF_XLEN-1:0]                          imm;
        logic [REG_W-1:0]                             rd;
        logic [DEF_TID_W-1:0]                         tid;
        logic [DEF_NUM_THREADS-1:0][DEF_XLEN-1:0]     rs1_data;
        logic [DEF_NUM_THREADS-1:0][DEF_XLEN-1:0]     rs2_data;
        logic [DEF_NUM_THREADS-1:0][DEF_XLEN-1:0]     rs3_data;
        logic                                         is_mstore;
    } disp_pkt_t;

    typedef struct packed {
        logic [UUID_W-1:0]                  uuid;
        logic [WIS_W-1:0]                   wis;
        logic [DEF_LANES-1:0]               tmask;
        logic [OP_TYPE_W-1:0]               op_type;
        logic [OP_MOD_W-1:0]                op_mod;
        logic                               wb;
        logic                               use_PC;
        logic                               use_imm;
        logic [DEF_XLEN-1:0]                PC;
        logic [DEF_XLEN-1:0]                imm;
        logic [REG_W-1:0]                   rd;
        logic [DEF_TID_W-1:0]               tid;
        logic [DEF_LANES-1:0][DEF_XLEN-1:0] rs1_data;
        logic [DEF_LANES-1:0][DEF_XLEN-1:0] rs2_data;
        logic [DEF_LANES-1:0][DEF_XLEN-1:0] rs3_data;
        logic                               is_mstore;
        logic [DEF_PID_W-1:0]               pid;
        logic                               sop;
        logic                               eop;
    } batch_pkt_t;

endpackage

// File: rtl/vx_batch_find_next.sv
// Finds the lowest active batch at or above start, and whether any active batch lies beyond it.
// Purely combinational; is_last is 1 when nothing is found.
module vx_batch_find_next #(
    parameter int BATCHES = 2,
    parameter int PID_W   = 1
) (
    input  logic [BATCHES-1:0] active,
    input  logic [PID_W:0]     start,
    output logic [PID_W-1:0]   next_pid,
    output logic               found,
    output logic               is_last
);

    always_comb begin
        next_pid = '0;
        found    = 1'b0;
        is_last  = 1'b1;
        // Descending scan so the lowest qualifying index is the one that sticks.
        for (int b = BATCHES - 1; b >= 0; b--) begin
            if (active[b] && (b >= int'(start))) begin
                next_pid = PID_W'(b);
                found    = 1'b1;
            end
        end
        for (int b = 0; b < BATCHES; b++) begin
            if (found && active[b] && (b > int'(next_pid))) begin
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vx_dispatch_batcher.sv
// Splits a wide dispatch packet into LANES-wide batches; 1-cycle latency, registered output held under backpressure.
// A new packet is taken on the last batch handshake; DISPATCH_BATCH_SKIP_EN drops batches with an empty tmask slice.
module vx_dispatch_batcher
    import vx_batch_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int LANES       = 4,
    parameter int XLEN        = 32
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         in_valid,
    input  logic [disp_w(NUM_THREADS, XLEN)-1:0]         in_data,
    output logic                                         in_ready,
    output logic                                         out_valid,
    output logic [batch_w(NUM_THREADS, LANES, XLEN)-1:0] out_data,
    input  logic                                         out_ready
);

    localparam int BATCHES = batches_of(NUM_THREADS, LANES);
    localparam int PID_W   = clog2_min1(BATCHES);
    localparam int TID_W   = clog2_min1(NUM_THREADS);

    if (LANES < 1 || (NUM_THREADS % LANES) != 0) begin : g_bad_lanes
        $error("vx_dispatch_batcher: LANES must divide NUM_THREADS");
    end

    typedef struct packed {
        logic [UUID_W-1:0]                    uuid;
        logic [WIS_W-1:0]                     wis;
        logic [NUM_THREADS-1:0]               tmask;
        logic [OP_TYPE_W-1:0]                 op_type;
        logic [OP_MOD_W-1:0]                  op_mod;
        logic                                 wb;
        logic                                 use_PC;
        logic                                 use_imm;
        logic [XLEN-1:0]                      PC;
        logic [XLEN-1:0]                      imm;
        logic [REG_W-1:0]                     rd;
        logic [TID_W-1:0]                     tid;
        logic [NUM_THREADS-1:0][XLEN-1:0]     rs1_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]     rs2_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]     rs3_data;
        logic                                 is_mstore;
    } disp_t;

    typedef struct packed {
        logic [UUID_W-1:0]              uuid;
        logic [WIS_W-1:0]               wis;
        logic [LANES-1:0]               tmask;
        logic [OP_TYPE_W-1:0]           op_type;
        logic [OP_MOD_W-1:0]            op_mod;
        logic                           wb;
        logic                           use_PC;
        logic                           use_imm;
        logic [XLEN-1:0]                PC;
        logic [XLEN-1:0]                imm;
        logic [REG_W-1:0]               rd;
        logic [TID_W-1:0]               tid;
        logic [LANES-1:0][XLEN-1:0]     rs1_data;
        logic [LANES-1:0][XLEN-1:0]     rs2_data;
        logic [LANES-1:0][XLEN-1:0]     rs3_data;
        logic                           is_mstore;
        logic [PID_W-1:0]               pid;
        logic                           sop;
        logic                           eop;
    } batch_t;

    disp_t            in_pkt, pkt_q, pkt_d;
    batch_t           out_b;
    state_e           state_q, state_d;
    logic [PID_W-1:0] pid_q, pid_d, first_pid, adv_pid;
    logic             sop_q, sop_d, eop_q, eop_d;
    logic [BATCHES-1:0] in_active, held_active;
    logic             first_found, first_last, adv_found, adv_last;
    logic             accept, fire;
    logic [TID_W-1:0] idx;

    assign in_pkt = in_data;

    for (genvar b = 0; b < BATCHES; b++) begin : g_active
`ifdef DISPATCH_BATCH_SKIP_EN
        assign in_active[b]   = |in_pkt.tmask[b*LANES +: LANES];
        assign held_active[b] = |pkt_q.tmask[b*LANES +: LANES];
`else
        assign in_active[b]   = 1'b1;
        assign held_active[b] = 1'b1;
`endif
    end

    vx_batch_find_next #(.BATCHES(BATCHES), .PID_W(PID_W)) u_find_first (
        .active   (in_active),
        .start    ('0),
        .next_pid (first_pid),
        .found    (first_found),
        .is_last  (first_last)
    );

    vx_batch_find_next #(.BATCHES(BATCHES), .PID_W(PID_W)) u_find_adv (
        .active   (held_active),
        .start    ({1'b0, pid_q} + (PID_W+1)'(1)),
        .next_pid (adv_pid),
        .found    (adv_found),
        .is_last  (adv_last)
    );

    assign out_valid = (state_q == BUSY);
    assign in_ready  = !reset && (!out_valid || (out_ready && eop_q));
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        pid_d   = pid_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        if (accept) begin
            // An all-empty packet still goes out once, as batch 0.
            state_d = BUSY;
            pkt_d   = in_pkt;
            pid_d   = first_found ? first_pid : '0;
            sop_d   = 1'b1;
            eop_d   = first_last;
        end else if (fire && eop_q) begin
            state_d = IDLE;
        end else if (fire) begin
            pid_d = adv_found ? adv_pid : pid_q;
            sop_d = 1'b0;
            eop_d = adv_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pkt_q   <= '0;
            pid_q   <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            pid_q   <= pid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    always_comb begin
        out_b           = '0;
        idx             = '0;
        out_b.uuid      = pkt_q.uuid;
        out_b.wis       = pkt_q.wis;
        out_b.op_type   = pkt_q.op_type;
        out_b.op_mod    = pkt_q.op_mod;
        out_b.wb        = pkt_q.wb;
        out_b.use_PC    = pkt_q.use_PC;
        out_b.use_imm   = pkt_q.use_imm;
        out_b.PC        = pkt_q.PC;
        out_b.imm       = pkt_q.imm;
        out_b.rd        = pkt_q.rd;
        out_b.tid       = pkt_q.tid;
        out_b.is_mstore = pkt_q.is_mstore;
        for (int l = 0; l < LANES; l++) begin
            idx                = TID_W'(int'(pid_q) * LANES + l);
            out_b.tmask[l]     = pkt_q.tmask[idx];
            out_b.rs1_data[l]  = pkt_q.rs1_data[idx];
            out_b.rs2_data[l]  = pkt_q.rs2_data[idx];
            out_b.rs3_data[l]  = pkt_q.rs3_data[idx];
        end
        out_b.pid = pid_q;
        out_b.sop = sop_q;
        out_b.eop = eop_q;
    end

    assign out_data = out_b;

endmodule

// File: tb/tb_vx_dispatch_batcher.sv
// Bench for vx_dispatch_batcher: directed table, corner sequences, random traffic against a queue model,
// and a LANES==NUM_THREADS instance. Expectations follow DISPATCH_BATCH_SKIP_EN when it is defined.
module tb_vx_dispatch_batcher;
    import vx_batch_pkg::*;

    localparam int NT = DEF_NUM_THREADS;
    localparam int LN = DEF_LANES;
    localparam int NB = DEF_BATCHES;
`ifdef DISPATCH_BATCH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct packed {
        logic [UUID_W-1:0]         uuid;
        logic [WIS_W-1:0]          wis;
        logic [7:0]                tmask;
        logic [OP_TYPE_W-1:0]      op_type;
        logic [OP_MOD_W-1:0]       op_mod;
        logic                      wb;
        logic                      use_PC;
        logic                      use_imm;
        logic [31:0]               PC;
        logic [31:0]               imm;
        logic [REG_W-1:0]          rd;
        logic [2:0]                tid;
        logic [7:0][31:0]          rs1_data;
        logic [7:0][31:0]          rs2_data;
        logic [7:0][31:0]          rs3_data;
        logic                      is_mstore;
        logic [0:0]                pid;
        logic                      sop;
        logic                      eop;
    } batch8_t;

    typedef struct {
        logic [NT-1:0] tmask;
        int            n;
        int            pid[2];
        logic [LN-1:0] tm[2];
    } vec_t;

    typedef int int_q_t[$];

    logic       clk = 1'b0;
    logic       reset, in_valid, in_ready, out_valid, out_ready;
    disp_pkt_t  in_pkt;
    batch_pkt_t out_pkt;
    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    disp_pkt_t  in_pkt8;
    batch8_t    out_pkt8;

    int vectors = 0;
    int miscompares = 0;
    batch_pkt_t q[$];

    always #5 clk = ~clk;

    vx_dispatch_batcher #(.NUM_THREADS(8), .LANES(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_pkt), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_pkt), .out_ready(out_ready)
    );

    vx_dispatch_batcher #(.NUM_THREADS(8), .LANES(8), .XLEN(32)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_data(in_pkt8), .in_ready(in_ready8),
        .out_valid(out_valid8), .out_data(out_pkt8), .out_ready(out_ready8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_batch(input string name, input batch_pkt_t act, input batch_pkt_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic disp_pkt_t make_pkt(input logic [NT-1:0] tm);
        disp_pkt_t p;
        p.uuid      = UUID_W'($urandom);
        p.wis       = WIS_W'($urandom);
        p.tmask     = tm;
        p.op_type   = OP_TYPE_W'($urandom);
        p.op_mod    = OP_MOD_W'($urandom);
        p.wb        = 1'($urandom);
        p.use_PC    = 1'($urandom);
        p.use_imm   = 1'($urandom);
        p.PC        = $urandom;
        p.imm       = $urandom;
        p.rd        = REG_W'($urandom);
        p.tid       = DEF_TID_W'($urandom);
        for (int t = 0; t < NT; t++) begin
            p.rs1_data[t] = $urandom;
            p.rs2_data[t] = $urandom;
            p.rs3_data[t] = $urandom;
        end
        p.is_mstore = 1'($urandom);
        return p;
    endfunction

    // Batch indices a packet produces, in emission order.
    function automatic int_q_t batch_list(input logic [NT-1:0] tm);
        int_q_t r;
        for (int b = 0; b < NB; b++) begin
            if (!SKIP || (|tm[b*LN +: LN])) r.push_back(b);
        end
        if (r.size() == 0) r.push_back(0);
        return r;
    endfunction

    function automatic batch_pkt_t exp_batch(input disp_pkt_t p, input int b, input bit s, input bit e);
        batch_pkt_t r;
        r.uuid      = p.uuid;
        r.wis       = p.wis;
        r.tmask     = p.tmask[b*LN +: LN];
        r.op_type   = p.op_type;
        r.op_mod    = p.op_mod;
        r.wb        = p.wb;
        r.use_PC    = p.use_PC;
        r.use_imm   = p.use_imm;
        r.PC        = p.PC;
        r.imm       = p.imm;
        r.rd        = p.rd;
        r.tid       = p.tid;
        for (int l = 0; l < LN; l++) begin
            r.rs1_data[l] = p.rs1_data[b*LN + l];
            r.rs2_data[l] = p.rs2_data[b*LN + l];
            r.rs3_data[l] = p.rs3_data[b*LN + l];
        end
        r.is_mstore = p.is_mstore;
        r.pid       = DEF_PID_W'(b);
        r.sop       = s;
        r.eop       = e;
        return r;
    endfunction

    task automatic push_pkt(input disp_pkt_t p);
        int_q_t pids = batch_list(p.tmask);
        for (int i = 0; i < pids.size(); i++) begin
            q.push_back(exp_batch(p, pids[i], i == 0, i == pids.size() - 1));
        end
    endtask

    function automatic vec_t mkv(input logic [NT-1:0] tmask, input int n,
                                 input int p0, input logic [LN-1:0] t0,
                                 input int p1, input logic [LN-1:0] t1);
        vec_t v;
        v.tmask = tmask;
        v.n     = n;
        v.pid[0] = p0;
        v.pid[1] = p1;
        v.tm[0]  = t0;
        v.tm[1]  = t1;
        return v;
    endfunction

    // Starts from idle with out_ready high; batches must come out on consecutive cycles.
    task automatic run_vec(input vec_t v, input int k);
        disp_pkt_t p = make_pkt(v.tmask);
        in_pkt = p;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d_in_ready", k), in_ready, 1);
        step();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) begin
                step();
                #1;
            end
            chk($sformatf("vec%0d_b%0d_valid", k, i), out_valid, 1);
            chk($sformatf("vec%0d_b%0d_pid", k, i), out_pkt.pid, v.pid[i]);
            chk($sformatf("vec%0d_b%0d_sop", k, i), out_pkt.sop, i == 0);
            chk($sformatf("vec%0d_b%0d_eop", k, i), out_pkt.eop, i == v.n - 1);
            chk($sformatf("vec%0d_b%0d_tmask", k, i), out_pkt.tmask, v.tm[i]);
            chk_batch($sformatf("vec%0d_b%0d_data", k, i), out_pkt,
                      exp_batch(p, v.pid[i], i == 0, i == v.n - 1));
        end
        step();
        #1;
        chk($sformatf("vec%0d_idle", k), out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          tbl[$];
        disp_pkt_t     p, p1, p2, prev8;
        logic [NT-1:0] tm;
        logic          exp_rdy;

`ifdef DISPATCH_BATCH_SKIP_EN
        tbl.push_back(mkv(8'hFF, 2, 0, 4'hF, 1, 4'hF));
        tbl.push_back(mkv(8'hF0, 1, 1, 4'hF, 0, 4'h0));
        tbl.push_back(mkv(8'h0F, 1, 0, 4'hF, 0, 4'h0));
        tbl.push_back(mkv(8'h00, 1, 0, 4'h0, 0, 4'h0));
        tbl.push_back(mkv(8'h30, 1, 1, 4'h3, 0, 4'h0));
        tbl.push_back(mkv(8'h81, 2, 0, 4'h1, 1, 4'h8));
`else
        tbl.push_back(mkv(8'hFF, 2, 0, 4'hF, 1, 4'hF));
        tbl.push_back(mkv(8'hF0, 2, 0, 4'h0, 1, 4'hF));
        tbl.push_back(mkv(8'h0F, 2, 0, 4'hF, 1, 4'h0));
        tbl.push_back(mkv(8'h00, 2, 0, 4'h0, 1, 4'h0));
        tbl.push_back(mkv(8'h30, 2, 0, 4'h0, 1, 4'h3));
        tbl.push_back(mkv(8'h81, 2, 0, 4'h1, 1, 4'h8));
`endif

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_pkt = '0;
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        in_pkt8 = '0;
        step();
        step();
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        step();
        #1;
        chk("post_reset_out_valid", out_valid, 0);

        for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k], k);

        // Second packet offered during the last-batch handshake of the first.
        p1 = make_pkt(8'hFF);
        p2 = make_pkt(8'hFF);
        in_pkt = p1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        step();
        in_pkt = p2;
        #1;
        chk("bb_in_ready_first", in_ready, 0);
        chk_batch("bb_p1_b0", out_pkt, exp_batch(p1, 0, 1'b1, 1'b0));
        step();
        #1;
        chk("bb_in_ready_last", in_ready, 1);
        chk_batch("bb_p1_b1", out_pkt, exp_batch(p1, 1, 1'b0, 1'b1));
        step();
        in_valid = 1'b0;
        #1;
        chk("bb_p2_valid", out_valid, 1);
        chk_batch("bb_p2_b0", out_pkt, exp_batch(p2, 0, 1'b1, 1'b0));
        step();
        #1;
        chk_batch("bb_p2_b1", out_pkt, exp_batch(p2, 1, 1'b0, 1'b1));
        step();
        #1;
        chk("bb_idle", out_valid, 0);

        // Five cycles of backpressure on the first batch.
        p = make_pkt(8'hFF);
        in_pkt = p;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        step();
        in_valid = 1'b0;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk_batch("bp_hold_data", out_pkt, exp_batch(p, 0, 1'b1, 1'b0));
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_in_ready", in_ready, 0);
            step();
            #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 0);
        step();
        #1;
        chk_batch("bp_b1", out_pkt, exp_batch(p, 1, 1'b0, 1'b1));
        chk("bp_b1_in_ready", in_ready, 1);
        step();
        #1;
        chk("bp_idle", out_valid, 0);

        // Reset while the first batch is stalled: the packet must vanish.
        p = make_pkt(8'hFF);
        in_pkt = p;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        step();
        in_valid = 1'b0;
        #1;
        chk("rst_pending_valid", out_valid, 1);
        reset = 1'b1;
        step();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_release_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            chk("rst_no_stale", out_valid, 0);
        end

        // Random traffic against the queue model.
        q.delete();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 4))
                0: tm = 8'hFF;
                1: tm = 8'hF0;
                2: tm = 8'h0F;
                3: tm = 8'h00;
                default: tm = NT'($urandom);
            endcase
            in_pkt = make_pkt(tm);
            #1;
            exp_rdy = (q.size() == 0) || (out_ready && q[0].eop);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            chk("rnd_in_ready", in_ready, exp_rdy);
            if (q.size() != 0) chk_batch("rnd_batch", out_pkt, q[0]);
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) push_pkt(in_pkt);
            step();
        end
        in_valid = 1'b0;

        // LANES == NUM_THREADS: plain one-cycle pipe at full rate.
        #1;
        chk("l8_reset_idle", out_valid8, 0);
        prev8 = '0;
        in_valid8 = 1'b1;
        out_ready8 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            p = make_pkt(NT'($urandom | 1));
            in_pkt8 = p;
            #1;
            chk("l8_in_ready", in_ready8, 1);
            if (c > 0) begin
                chk("l8_out_valid", out_valid8, 1);
                chk("l8_rs1_lane7", out_pkt8.rs1_data[7], prev8.rs1_data[7]);
                chk("l8_tmask", out_pkt8.tmask, prev8.tmask);
                chk("l8_pid", out_pkt8.pid, 0);
                chk("l8_sop", out_pkt8.sop, 1);
                chk("l8_eop", out_pkt8.eop, 1);
            end
            prev8 = p;
            step();
        end
        in_valid8 = 1'b0;
        #1;
        chk("l8_last_rs1_lane7", out_pkt8.rs1_data[7], prev8.rs1_data[7]);
        step();
        #1;
        chk("l8_idle", out_valid8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
